ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the sending end of the keyboard link whose receiving end is the `Keyboard` block. It sends one command/data byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, with odd parity. It runs the full inhibit / request-to-send / device-clocked shift / acknowledge sequence and reports completion, NACK or timeout. The receiver in `Keyboard` must ignore the lines while `tx_idle` is 0.

---
 rtl/ps2_host_tx.sv | 170 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : Host-to-device PS/2 transmitter. Sends one byte with odd parity
//             using the inhibit / request-to-send / device-clocked shift /
//             acknowledge sequence. Reports completion, NACK, or timeout.
//  Ports    : clk             - system clock
//             rst             - synchronous reset, active low
//             wr_ps2          - start pulse, honoured only while tx_idle = 1
//             din[7:0]        - byte to send, captured on the accepted start
//             ps2c / ps2d     - open-drain PS/2 clock / data (0 or Z only)
//             tx_idle         - 1 when no transfer is in progress
//             tx_done_tick    - one-cycle pulse when a transfer completes
//             tx_nack         - ACK bit of the last completed transfer (1 = NACK)
//             tx_timeout_tick - one-cycle pulse when a transfer is aborted
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
  parameter int RQST_CYCLES    = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_nack,
  output logic       tx_timeout_tick
);

  // One counter serves both the request phase and the inter-edge timeout.
  localparam int c_MAX_CNT = (RQST_CYCLES > TIMEOUT_CYCLES) ? RQST_CYCLES : TIMEOUT_CYCLES;
  localparam int c_CW      = $clog2(c_MAX_CNT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RTS   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  state_t            r_state;
  logic [7:0]        r_filt;
  logic              r_fclk;
  logic              w_fclk_nxt;
  logic              w_fall;
  logic [8:0]        r_frame;
  logic [3:0]        r_n;
  logic [c_CW-1:0]   r_cnt;
  logic              r_c_low;
  logic              r_d_low;

  // Open-drain drivers: pull low or release, never drive high.
  assign ps2c = r_c_low ? 1'b0 : 1'bz;
  assign ps2d = r_d_low ? 1'b0 : 1'bz;

  // Filtered clock changes only after 8 identical samples; otherwise holds.
  always_comb begin
    w_fclk_nxt = r_fclk;
    if (r_filt == 8'hFF)
      w_fclk_nxt = 1'b1;
    else if (r_filt == 8'h00)
      w_fclk_nxt = 1'b0;
  end

  assign w_fall = r_fclk & ~w_fclk_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_filt <= 8'hFF;
      r_fclk <= 1'b1;
    end else begin
      r_filt <= {ps2c, r_filt[7:1]};
      r_fclk <= w_fclk_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_frame         <= 9'd0;
      r_n             <= 4'd0;
      r_cnt           <= '0;
      r_c_low         <= 1'b0;
      r_d_low         <= 1'b0;
      tx_idle         <= 1'b1;
      tx_done_tick    <= 1'b0;
      tx_nack         <= 1'b0;
      tx_timeout_tick <= 1'b0;
    end else begin
      tx_done_tick    <= 1'b0;
      tx_timeout_tick <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wr_ps2) begin
            r_frame <= {~^din, din};
            r_n     <= 4'd0;
            r_cnt   <= '0;
            r_c_low <= 1'b1;
            tx_idle <= 1'b0;
            r_state <= ST_RTS;
          end
        end

        ST_RTS: begin
          if (r_cnt == c_CW'(RQST_CYCLES - 1)) begin
            // Release the clock and present the start bit together.
            r_c_low <= 1'b0;
            r_d_low <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_START;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end

        ST_START, ST_DATA, ST_STOP, ST_WAIT: begin
          // A device edge takes priority over a coincident timeout expiry.
          if (w_fall) begin
            r_cnt <= '0;
            case (r_state)
              ST_START, ST_DATA: begin
                if (r_n == 4'd9) begin
                  r_d_low <= 1'b0;          // stop bit: release data
                  r_state <= ST_STOP;
                end else begin
                  r_d_low <= ~r_frame[0];
                  r_frame <= {1'b0, r_frame[8:1]};
                  r_n     <= r_n + 4'd1;
                  r_state <= ST_DATA;
                end
              end
              ST_STOP: begin
                tx_nack <= ps2d;            // device pulls data low to ACK
                r_state <= ST_WAIT;
              end
              default: ;
            endcase
          end else if (r_state == ST_WAIT && r_fclk && ps2d) begin
            tx_done_tick <= 1'b1;
            tx_idle      <= 1'b1;
            r_state      <= ST_IDLE;
          end else if (r_cnt == c_CW'(TIMEOUT_CYCLES - 1)) begin
            r_c_low         <= 1'b0;
            r_d_low         <= 1'b0;
            tx_timeout_tick <= 1'b1;
            tx_idle         <= 1'b1;
            r_state         <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end

        default: begin
          r_c_low <= 1'b0;
          r_d_low <= 1'b0;
          tx_idle <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Purpose  : Self-checking bench for ps2_host_tx. A PS/2 device model clocks
//             frames out of the host while a cycle-level reference model,
//             built from the protocol rules, predicts every host output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

  localparam int c_R = 50;
  localparam int c_T = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr  = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  wire        ps2c;
  wire        ps2d;
  logic       tx_idle, tx_done_tick, tx_nack, tx_timeout_tick;

  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;
  pullup (ps2c);
  pullup (ps2d);

  ps2_host_tx #(.RQST_CYCLES(c_R), .TIMEOUT_CYCLES(c_T)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_ps2          (wr),
    .din             (din),
    .ps2c            (ps2c),
    .ps2d            (ps2d),
    .tx_idle         (tx_idle),
    .tx_done_tick    (tx_done_tick),
    .tx_nack         (tx_nack),
    .tx_timeout_tick (tx_timeout_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transfer progress is described by: cycles of inhibit left, number of
  // device falls consumed, and cycles since the last fall.
  bit         m_active = 1'b0;
  int         m_rts = 0;
  int         m_nf = 0;
  int         m_quiet = 0;
  logic [8:0] m_frame = 9'd0;
  bit         m_nack = 1'b0;
  bit         m_done = 1'b0;
  bit         m_to = 1'b0;
  logic [7:0] m_hist = 8'hFF;
  bit         m_fclk = 1'b1;

  always @(posedge clk) begin : model
    bit nxt;
    bit fall;
    nxt  = (m_hist == 8'hFF) ? 1'b1 : ((m_hist == 8'h00) ? 1'b0 : m_fclk);
    fall = m_fclk && !nxt;
    m_done = 1'b0;
    m_to   = 1'b0;
    if (!rst) begin
      m_active = 1'b0; m_rts = 0; m_nf = 0; m_quiet = 0;
      m_nack = 1'b0; m_hist = 8'hFF; m_fclk = 1'b1;
    end else begin
      if (!m_active) begin
        if (wr) begin
          m_active = 1'b1;
          m_rts    = c_R;
          m_nf     = 0;
          m_quiet  = 0;
          m_frame  = {(($countones(din) % 2) == 0) ? 1'b1 : 1'b0, din};
        end
      end else if (m_rts > 0) begin
        m_rts--;
        if (m_rts == 0) m_quiet = 0;
      end else if (fall) begin
        if (m_nf == 10) m_nack = (ps2d === 1'b1);
        if (m_nf < 11) m_nf++;
        m_quiet = 0;
      end else if (m_nf == 11 && m_fclk && ps2d === 1'b1) begin
        m_done   = 1'b1;
        m_active = 1'b0;
      end else begin
        m_quiet++;
        if (m_quiet == c_T) begin
          m_to     = 1'b1;
          m_active = 1'b0;
        end
      end
      m_hist = {ps2c, m_hist[7:1]};
      m_fclk = nxt;
    end
  end

  function automatic logic exp_c_level();
    return (m_active && m_rts > 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic exp_d_level();
    if (!m_active || m_rts > 0) return 1'b1;
    if (m_nf == 0) return 1'b0;
    if (m_nf <= 9) return m_frame[m_nf-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_cnt++;
    if (tx_timeout_tick === 1'b1) to_cnt++;
    if (chk_en) begin
      chk1("idle", tx_idle, m_active ? 1'b0 : 1'b1);
      chk1("done_tick", tx_done_tick, m_done);
      chk1("timeout_tick", tx_timeout_tick, m_to);
      chk1("nack", tx_nack, m_nack);
      if (!dev_c_low) chk1("ps2c_line", ps2c, exp_c_level());
      if (!dev_d_low) chk1("ps2d_line", ps2d, exp_d_level());
    end
  end

  // ---------------- device model ----------------
  // bits[0..7] data, bits[8] parity, bits[9] stop, each sampled on the rising clock.
  task automatic dev_frame(input int nf, input bit ack, input int half,
                           input int inj_at, input int inj_kind,
                           output logic [10:0] bits, output int rts_len);
    int waitc;
    bits    = '0;
    rts_len = 0;
    waitc   = 0;
    while (ps2c !== 1'b0 && waitc < 200) begin @(negedge clk); waitc++; end
    while (ps2c === 1'b0 && waitc < 400) begin rts_len++; @(negedge clk); waitc++; end
    chk1("start_bit", ps2d, 1'b0);
    repeat (half) @(negedge clk);
    for (int i = 1; i <= nf; i++) begin
      dev_c_low = 1'b1;
      repeat (half) @(negedge clk);
      dev_c_low = 1'b0;
      bits[i-1] = ps2d;
      if (i == 10 && ack) dev_d_low = 1'b1;
      if (i == 11) dev_d_low = 1'b0;
      if (i == inj_at) begin
        if (inj_kind == 1) begin
          wr = 1'b1; din = 8'hFF;
          @(negedge clk);
          wr = 1'b0;
        end
        if (inj_kind == 2) begin
          rst = 1'b0;
          @(negedge clk);
          chk1("rst_ps2d_released", ps2d, 1'b1);
          chk1("rst_ps2c_released", ps2c, 1'b1);
          chk1("rst_idle", tx_idle, 1'b1);
          chk1("rst_done", tx_done_tick, 1'b0);
          chk1("rst_timeout", tx_timeout_tick, 1'b0);
          rst = 1'b1;
          return;
        end
      end
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b, input int nf, input bit ack,
                      input int inj_at, input int inj_kind,
                      output logic [10:0] bits, output int rl);
    int half;
    half = $urandom_range(20, 40);
    @(negedge clk);
    din = b; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; din = 8'($urandom);
    dev_frame(nf, ack, half, inj_at, inj_kind, bits, rl);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tx_idle !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    chk1("idle_within_budget", (n < budget) ? 1'b1 : 1'b0, 1'b1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [10:0] bits;
    int          rl;
    int          d0, t0;
    logic [7:0]  b;
    bit          ack;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk1("reset_idle", tx_idle, 1'b1);
    chk1("reset_done", tx_done_tick, 1'b0);
    chk1("reset_nack", tx_nack, 1'b0);
    chk1("reset_timeout", tx_timeout_tick, 1'b0);
    chk1("reset_ps2c", ps2c, 1'b1);
    chk1("reset_ps2d", ps2d, 1'b1);
    chk_en = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED with ACK
    d0 = done_cnt; t0 = to_cnt;
    send(8'hED, 11, 1'b1, 0, 0, bits, rl);
    wait_idle(3000);
    chk8("ed_rts_len", 8'(rl), 8'd50);
    chk8("ed_byte", bits[7:0], 8'hED);
    chk1("ed_parity", bits[8], 1'b1);
    chk1("ed_stop", bits[9], 1'b1);
    chk8("ed_done_count", 8'(done_cnt - d0), 8'd1);
    chk8("ed_timeout_count", 8'(to_cnt - t0), 8'd0);
    chk1("ed_nack", tx_nack, 1'b0);

    // parity corners
    send(8'h00, 11, 1'b1, 0, 0, bits, rl);
    wait_idle(3000);
    chk8("x00_byte", bits[7:0], 8'h00);
    chk1("x00_parity", bits[8], 1'b1);
    send(8'h01, 11, 1'b1, 0, 0, bits, rl);
    wait_idle(3000);
    chk8("x01_byte", bits[7:0], 8'h01);
    chk1("x01_parity", bits[8], 1'b0);

    // NACK
    d0 = done_cnt;
    send(8'h55, 11, 1'b0, 0, 0, bits, rl);
    wait_idle(3000);
    chk8("nack_done_count", 8'(done_cnt - d0), 8'd1);
    chk1("nack_flag", tx_nack, 1'b1);

    // random frames
    for (int k = 0; k < 6; k++) begin
      b   = 8'($urandom);
      ack = 1'($urandom);
      d0  = done_cnt;
      send(b, 11, ack, 0, 0, bits, rl);
      wait_idle(3000);
      chk8("rand_byte", bits[7:0], b);
      chk1("rand_parity", bits[8], (($countones(b) % 2) == 0) ? 1'b1 : 1'b0);
      chk1("rand_stop", bits[9], 1'b1);
      chk1("rand_nack", tx_nack, ack ? 1'b0 : 1'b1);
      chk8("rand_done_count", 8'(done_cnt - d0), 8'd1);
    end

    // start request during DATA is ignored
    d0 = done_cnt;
    send(8'h3C, 11, 1'b1, 4, 1, bits, rl);
    wait_idle(3000);
    chk8("ignored_byte", bits[7:0], 8'h3C);
    chk8("ignored_done_count", 8'(done_cnt - d0), 8'd1);

    // timeout after 4 falls; nack holds its previous value (0 from last ACK)
    d0 = done_cnt; t0 = to_cnt;
    send(8'h96, 4, 1'b1, 0, 0, bits, rl);
    wait_idle(3000);
    chk8("timeout_count", 8'(to_cnt - t0), 8'd1);
    chk8("timeout_done_count", 8'(done_cnt - d0), 8'd0);
    chk1("timeout_nack_held", tx_nack, 1'b0);
    chk1("timeout_ps2c", ps2c, 1'b1);
    chk1("timeout_ps2d", ps2d, 1'b1);

    // NACK first so the reset visibly clears tx_nack
    send(8'h12, 11, 1'b0, 0, 0, bits, rl);
    wait_idle(3000);
    d0 = done_cnt; t0 = to_cnt;
    send(8'hA5, 11, 1'b1, 4, 2, bits, rl);
    repeat (5) @(negedge clk);
    chk1("after_rst_nack", tx_nack, 1'b0);
    chk8("after_rst_done_count", 8'(done_cnt - d0), 8'd0);
    chk8("after_rst_timeout_count", 8'(to_cnt - t0), 8'd0);
    send(8'hF4, 11, 1'b1, 0, 0, bits, rl);
    wait_idle(3000);
    chk8("f4_byte", bits[7:0], 8'hF4);
    chk8("f4_done_count", 8'(done_cnt - d0), 8'd1);

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
